axilite_slave_regfile: RTL and testbench



---
 rtl/axilite_slave_regfile.sv | 277 +++++++++++++++++++++++++++
 tb/tb_axilite_slave_regfile.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axilite_slave_regfile.sv
// axilite_slave_regfile
//
// AXI4-Lite slave register file. Write address and write data are accepted
// independently and in either order; the write commits on the edge where both
// are available (held or handshaking). Reads are single-beat and served from
// the register bank with one cycle of latency. Register 0 is a read-only
// version word; registers 1..NUM_REGS-1 are read/write with byte strobes.
//
// Ports:
//   ACLK, ARESETN              clock, asynchronous active-low reset
//   AWADDR/AWVALID/AWREADY     write address channel
//   WDATA/WSTRB/WVALID/WREADY  write data channel
//   BRESP/BVALID/BREADY        write response channel (OKAY / SLVERR)
//   ARADDR/ARVALID/ARREADY     read address channel
//   RDATA/RRESP/RVALID/RREADY  read data channel (OKAY / SLVERR)
//
// All outputs are driven from flops or from flop-only logic, so no output
// depends combinationally on any VALID or READY input.

module axilite_slave_regfile #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 16,
  parameter logic [31:0] VERSION    = 32'hA11E_0001
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  // Write address channel
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  // Write data channel
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WVALID,
  output logic                    WREADY,
  // Write response channel
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  // Read address channel
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  // Read data channel
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RVALID,
  input  logic                    RREADY
);

  localparam int unsigned IdxW  = ADDR_WIDTH - 2;
  localparam int unsigned StrbW = DATA_WIDTH / 8;

  // NUM_REGS may equal 2^IdxW, so it needs one bit more than an index.
  localparam logic [IdxW:0] NumRegsExt = (IdxW + 1)'(NUM_REGS);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // Index lies inside the implemented register bank (including register 0).
  function automatic logic idx_in_range(input logic [IdxW-1:0] idx);
    return ({1'b0, idx} < NumRegsExt);
  endfunction

  // Per-byte merge of new data into the old register value.
  function automatic logic [DATA_WIDTH-1:0] strb_merge(input logic [DATA_WIDTH-1:0] old_val,
                                                       input logic [DATA_WIDTH-1:0] new_val,
                                                       input logic [StrbW-1:0]      strb);
    logic [DATA_WIDTH-1:0] res;
    res = old_val;
    for (int b = 0; b < StrbW; b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = new_val[8*b +: 8];
      end
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------

  // Ready outputs stay low through the first edge after reset release.
  logic live_q;

  logic                  aw_held_q, aw_held_d;
  logic [IdxW-1:0]       aw_idx_q, aw_idx_d;
  logic                  w_held_q, w_held_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [StrbW-1:0]      w_strb_q, w_strb_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;

  logic                  rvalid_q, rvalid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  // Register 0 is the constant version word and has no storage.
  logic [DATA_WIDTH-1:0] regs_q [1:NUM_REGS-1];
  logic [DATA_WIDTH-1:0] regs_d [1:NUM_REGS-1];

  // Byte-offset address bits do not participate in decode.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{AWADDR[1:0], ARADDR[1:0]};

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------

  logic awready, wready, arready;
  logic aw_hs, w_hs, ar_hs;

  assign awready = live_q & ~aw_held_q & ~bvalid_q;
  assign wready  = live_q & ~w_held_q & ~bvalid_q;
  assign arready = live_q & ~rvalid_q;

  assign aw_hs = AWVALID & awready;
  assign w_hs  = WVALID & wready;
  assign ar_hs = ARVALID & arready;

  // ---------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------

  logic                  commit;
  logic [IdxW-1:0]       wr_idx;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [StrbW-1:0]      wr_strb;
  logic                  wr_ok;

  // Held values take priority; otherwise the same-edge handshake supplies them.
  assign wr_idx  = aw_held_q ? aw_idx_q : AWADDR[ADDR_WIDTH-1:2];
  assign wr_data = w_held_q ? w_data_q : WDATA;
  assign wr_strb = w_held_q ? w_strb_q : WSTRB;
  assign commit  = (aw_held_q | aw_hs) & (w_held_q | w_hs);
  assign wr_ok   = idx_in_range(wr_idx) && (wr_idx != '0);

  always_comb begin
    aw_held_d = aw_held_q;
    aw_idx_d  = aw_idx_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    regs_d    = regs_q;

    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      if (wr_ok) begin
        bresp_d = RespOkay;
        for (int i = 1; i < NUM_REGS; i++) begin
          if (wr_idx == IdxW'(i)) begin
            regs_d[i] = strb_merge(regs_q[i], wr_data, wr_strb);
          end
        end
      end else begin
        bresp_d = RespSlvErr;
      end
    end else begin
      if (aw_hs) begin
        aw_held_d = 1'b1;
        aw_idx_d  = AWADDR[ADDR_WIDTH-1:2];
      end
      if (w_hs) begin
        w_held_d = 1'b1;
        w_data_d = WDATA;
        w_strb_d = WSTRB;
      end
    end

    // A commit cannot coincide with a pending response: readies are low then.
    if (bvalid_q && BREADY) begin
      bvalid_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------

  logic [IdxW-1:0]       rd_idx;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  rd_err;

  assign rd_idx = ARADDR[ADDR_WIDTH-1:2];

  // Reads see regs_q, so a read racing a commit to the same index returns
  // the pre-write value.
  always_comb begin
    rd_word = '0;
    rd_err  = 1'b0;
    if (!idx_in_range(rd_idx)) begin
      rd_err = 1'b1;
    end else if (rd_idx == '0) begin
      rd_word = VERSION;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (rd_idx == IdxW'(i)) begin
          rd_word = regs_q[i];
        end
      end
    end
  end

  always_comb begin
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_word;
      rresp_d  = rd_err ? RespSlvErr : RespOkay;
    end else if (rvalid_q && RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Flops
  // ---------------------------------------------------------------------------

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      live_q    <= 1'b0;
      aw_held_q <= 1'b0;
      aw_idx_q  <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RespOkay;
      rvalid_q  <= 1'b0;
      rresp_q   <= RespOkay;
      rdata_q   <= '0;
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      live_q    <= 1'b1;
      aw_held_q <= aw_held_d;
      aw_idx_q  <= aw_idx_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------

  assign AWREADY = awready;
  assign WREADY  = wready;
  assign ARREADY = arready;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign RVALID  = rvalid_q;
  assign RRESP   = rresp_q;
  assign RDATA   = rdata_q;

endmodule

// File: tb/tb_axilite_slave_regfile.sv
// Testbench for axilite_slave_regfile. Expected responses are pushed onto
// queues as stimulus is driven and popped by a monitor as the DUT responds.

module tb_axilite_slave_regfile;

  localparam logic [31:0] Version = 32'hA11E_0001;
  localparam int          NRegs   = 16;

  logic        ACLK;
  logic        ARESETN;
  logic [7:0]  AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [7:0]  ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;

  axilite_slave_regfile #(
    .ADDR_WIDTH (8),
    .DATA_WIDTH (32),
    .NUM_REGS   (NRegs),
    .VERSION    (Version)
  ) u_dut (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .AWADDR  (AWADDR),
    .AWVALID (AWVALID),
    .AWREADY (AWREADY),
    .WDATA   (WDATA),
    .WSTRB   (WSTRB),
    .WVALID  (WVALID),
    .WREADY  (WREADY),
    .BRESP   (BRESP),
    .BVALID  (BVALID),
    .BREADY  (BREADY),
    .ARADDR  (ARADDR),
    .ARVALID (ARVALID),
    .ARREADY (ARREADY),
    .RDATA   (RDATA),
    .RRESP   (RRESP),
    .RVALID  (RVALID),
    .RREADY  (RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] model [NRegs];
  logic [1:0]  bq [$];
  logic [33:0] rq [$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: a handshake seen at the falling edge completes on the next rise.
  always @(negedge ACLK) begin
    if (ARESETN) begin
      if (BVALID && BREADY) begin
        if (bq.size() == 0) check_eq("b_unexpected", 64'(BVALID), 64'd0);
        else check_eq("bresp", 64'(BRESP), 64'(bq.pop_front()));
      end
      if (RVALID && RREADY) begin
        if (rq.size() == 0) begin
          check_eq("r_unexpected", 64'(RVALID), 64'd0);
        end else begin
          logic [33:0] e;
          e = rq.pop_front();
          check_eq("rdata", 64'(RDATA), 64'(e[31:0]));
          check_eq("rresp", 64'(RRESP), 64'(e[33:32]));
        end
      end
    end
  end

  // All tasks start and end just after a rising edge.
  task automatic write_txn(input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly);
    bit aw_done = 0;
    bit w_done  = 0;
    int cyc     = 0;
    int idx     = int'(addr[7:2]);
    if (idx == 0 || idx >= NRegs) begin
      bq.push_back(2'b10);
    end else begin
      bq.push_back(2'b00);
      for (int b = 0; b < 4; b++) if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
    end
    AWADDR = addr;
    WDATA  = data;
    WSTRB  = strb;
    while (!(aw_done && w_done) && cyc < 50) begin
      AWVALID = !aw_done && (cyc >= aw_dly);
      WVALID  = !w_done && (cyc >= w_dly);
      @(negedge ACLK);
      if (AWVALID && AWREADY) aw_done = 1;
      if (WVALID && WREADY) w_done = 1;
      @(posedge ACLK);
      #1;
      cyc++;
    end
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    check_eq("wr_hs", 64'({aw_done, w_done}), 64'b11);
  endtask

  task automatic read_exp(input logic [7:0] addr, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp);
    bit done = 0;
    int cyc  = 0;
    rq.push_back({exp_resp, exp_data});
    ARADDR = addr;
    while (!done && cyc < 50) begin
      ARVALID = 1'b1;
      @(negedge ACLK);
      done = ARREADY;
      @(posedge ACLK);
      #1;
      cyc++;
    end
    ARVALID = 1'b0;
    check_eq("rd_hs", 64'(done), 64'd1);
  endtask

  task automatic read_txn(input logic [7:0] addr);
    int idx = int'(addr[7:2]);
    if (idx == 0) read_exp(addr, Version, 2'b00);
    else if (idx >= NRegs) read_exp(addr, 32'h0, 2'b10);
    else read_exp(addr, model[idx], 2'b00);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(bq.size() == 0 && rq.size() == 0 && !BVALID && !RVALID) && n < 50) begin
      @(posedge ACLK);
      #1;
      n++;
    end
    if (n == 50) check_eq("idle_timeout", 64'(bq.size() + rq.size()) + 64'(BVALID), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1);
  end

  initial begin
    logic [31:0] cap;
    ARESETN = 1'b0;
    AWADDR = '0; AWVALID = 0; WDATA = '0; WSTRB = '0; WVALID = 0; BREADY = 1;
    ARADDR = '0; ARVALID = 0; RREADY = 1;
    for (int i = 0; i < NRegs; i++) model[i] = '0;

    // Reset state
    repeat (3) @(posedge ACLK);
    #1;
    check_eq("rst_awready", 64'(AWREADY), 0);
    check_eq("rst_wready", 64'(WREADY), 0);
    check_eq("rst_arready", 64'(ARREADY), 0);
    check_eq("rst_bvalid", 64'(BVALID), 0);
    check_eq("rst_rvalid", 64'(RVALID), 0);
    check_eq("rst_bresp", 64'(BRESP), 0);
    check_eq("rst_rresp", 64'(RRESP), 0);
    check_eq("rst_rdata", 64'(RDATA), 0);
    ARESETN = 1'b1;
    @(negedge ACLK);
    check_eq("first_edge_awready", 64'(AWREADY), 0);
    check_eq("first_edge_wready", 64'(WREADY), 0);
    check_eq("first_edge_arready", 64'(ARREADY), 0);
    @(posedge ACLK);
    #1;
    check_eq("live_awready", 64'(AWREADY), 1);
    check_eq("live_wready", 64'(WREADY), 1);
    check_eq("live_arready", 64'(ARREADY), 1);

    // Version word
    read_txn(8'h00);
    check_eq("r_latency", 64'(RVALID), 1);
    wait_idle();

    // Same-cycle AW+W then readback
    write_txn(8'h04, 32'hDEADBEEF, 4'hF, 0, 0);
    check_eq("b_latency", 64'(BVALID), 1);
    wait_idle();
    read_txn(8'h04);
    wait_idle();

    // W three cycles ahead of AW, partial strobes
    write_txn(8'h08, 32'h12345678, 4'b0101, 3, 0);
    wait_idle();
    read_exp(8'h08, 32'h00340078, 2'b00);
    // AW ahead of W, low address bits ignored
    write_txn(8'h0F, 32'hA5A5A5A5, 4'b1000, 0, 2);
    wait_idle();
    read_txn(8'h0C);
    write_txn(8'h0C, 32'hFFFFFFFF, 4'h0, 0, 0);
    wait_idle();
    read_txn(8'h0C);
    wait_idle();

    // Error decode
    write_txn(8'h00, 32'h11111111, 4'hF, 0, 0);
    write_txn(8'h40, 32'h22222222, 4'hF, 0, 0);
    wait_idle();
    read_txn(8'h00);
    read_txn(8'h40);
    read_txn(8'h43);
    read_txn(8'h04);
    wait_idle();

    // Read racing a write to the same index returns the old value
    cap = model[4];
    fork
      read_exp(8'h10, cap, 2'b00);
      write_txn(8'h10, 32'h55AA55AA, 4'hF, 0, 0);
    join
    wait_idle();
    read_txn(8'h10);
    wait_idle();

    // Backpressure on both response channels
    BREADY = 1'b0;
    RREADY = 1'b0;
    write_txn(8'h18, 32'hCAFEF00D, 4'hF, 0, 0);
    read_txn(8'h04);
    for (int c = 0; c < 5; c++) begin
      @(negedge ACLK);
      check_eq("bp_bvalid", 64'(BVALID), 1);
      check_eq("bp_bresp", 64'(BRESP), 0);
      check_eq("bp_rvalid", 64'(RVALID), 1);
      check_eq("bp_rdata", 64'(RDATA), 64'(model[1]));
      check_eq("bp_rresp", 64'(RRESP), 0);
      check_eq("bp_ready", 64'({AWREADY, WREADY, ARREADY}), 0);
    end
    @(posedge ACLK);
    #1;
    BREADY = 1'b1;
    RREADY = 1'b1;
    wait_idle();
    check_eq("bp_release", 64'({AWREADY, WREADY, ARREADY}), 64'b111);
    read_txn(8'h18);
    wait_idle();

    // Random traffic
    for (int k = 0; k < 20; k++) begin
      logic [7:0] a;
      a = 8'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
      write_txn(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                $urandom_range(0, 3));
      read_txn(8'($urandom_range(0, 19) * 4));
      read_txn(a);
    end
    wait_idle();

    // Reset with only the AW half of a write accepted
    write_txn(8'h0C, 32'h0BADF00D, 4'hF, 0, 0);
    wait_idle();
    AWADDR  = 8'h0C;
    AWVALID = 1'b1;
    @(negedge ACLK);
    check_eq("mid_aw_hs", 64'(AWREADY), 1);
    @(posedge ACLK);
    #1;
    AWVALID = 1'b0;
    ARESETN = 1'b0;
    for (int i = 0; i < NRegs; i++) model[i] = '0;
    #1;
    check_eq("mid_rst_outs", 64'({BVALID, RVALID, AWREADY, WREADY, ARREADY}), 0);
    repeat (2) @(posedge ACLK);
    #1;
    ARESETN = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge ACLK);
      check_eq("mid_rst_no_b", 64'(BVALID), 0);
    end
    @(posedge ACLK);
    #1;
    read_txn(8'h0C);
    read_txn(8'h04);
    write_txn(8'h10, 32'h11223344, 4'hF, 0, 0);
    wait_idle();
    read_txn(8'h10);
    read_txn(8'h0C);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
